data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_if.sv | 19 +
 rtl/data_memory.sv | 81 ++++++++
 tb/tb_data_memory.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// data_memory_if: request/response bus between a core (master) and the data memory (slave)
interface data_memory_if;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     mem_addr;
  logic            mem_write_en;
  logic [0:3][7:0] mem_data_in;
  logic [0:3][7:0] mem_data_out;
  logic            resp_valid;
  logic            misalign_err;
  modport master (
    output req_valid, mem_addr, mem_write_en, mem_data_in,
    input  req_ready, mem_data_out, resp_valid, misalign_err
  );
  modport slave (
    input  req_valid, mem_addr, mem_write_en, mem_data_in,
    output req_ready, mem_data_out, resp_valid, misalign_err
  );
endinterface

// File: rtl/data_memory.sv
// data_memory: fixed-latency single-port word memory; optional misalignment check via DATA_MEM_MISALIGN_CHECK_EN
module data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic         clk,
  input logic         rst_b,
  data_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            we_q, we_d, mis_q, mis_d, resp_q, resp_d, err_q, err_d;
  logic [31:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic            accept, mis_in, mem_we;
  assign bus.req_ready    = state_q == IDLE && !rst_b;
  assign accept           = bus.req_valid && bus.req_ready;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign mis_in           = bus.mem_addr[1:0] != 2'b00;
`else
  assign mis_in           = 1'b0;
`endif
  // The access itself (write or read sample) happens on the RESP->IDLE edge, so the
  // registered response is visible in the first IDLE cycle.
  assign mem_we           = state_q == RESP && we_q && !mis_q;
  assign bus.resp_valid   = resp_q;
  assign bus.misalign_err = err_q;
  assign bus.mem_data_out = rdata_q;
  // Next state: latch request on acceptance, count down in BUSY, build the response in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = accept ? bus.mem_addr[AW+1:2] : idx_q;
    we_d    = accept ? bus.mem_write_en : we_q;
    wdata_d = accept ? bus.mem_data_in : wdata_q;
    mis_d   = accept ? mis_in : mis_q;
    if (accept) begin
      state_d = LATENCY > 1 ? BUSY : RESP;
      cnt_d   = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
    end
    if (state_q == BUSY) begin
      state_d = cnt_q == 4'd0 ? RESP : BUSY;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end
    if (state_q == RESP) state_d = IDLE;
    resp_d  = state_q == RESP;
    err_d   = state_q == RESP && mis_q;
    rdata_d = (state_q != RESP || mis_q) ? 32'd0 : we_q ? wdata_q : mem_q[idx_q];
  end
  // Control and response registers; a reset drops any pending request
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and random transactions checked against a word-array reference model
module tb_data_memory;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;
  logic clk = 1'b0;
  logic rst_b;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] mm [DEPTH];
  bit          wr [DEPTH];
  logic [31:0] obs;
  data_memory_if bus ();
  data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic we, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_err, input bit chk_d,
                     output logic [31:0] o);
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("idle_data", bus.mem_data_out, 32'd0);
    bus.req_valid = 1'b1;
    bus.mem_addr = a;
    bus.mem_write_en = we;
    bus.mem_data_in = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_addr = $urandom;
    bus.mem_write_en = 1'($urandom);
    bus.mem_data_in = $urandom;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("wait_resp", {31'd0, bus.resp_valid}, 32'd0);
      chk("wait_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    chk("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("resp_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("resp_err", {31'd0, bus.misalign_err}, {31'd0, exp_err});
    if (chk_d) chk("resp_data", bus.mem_data_out, exp_d);
    o = bus.mem_data_out;
  endtask

  task automatic op(input logic [31:0] a, input logic we, input logic [31:0] d, output logic [31:0] o);
    int w = int'((a >> 2) % DEPTH);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    logic mis = a % 4 != 0;
`else
    logic mis = 1'b0;
`endif
    txn(a, we, d, mis ? 32'd0 : we ? d : mm[w], mis, mis || we || wr[w], o);
    if (we && !mis) begin
      mm[w] = d;
      wr[w] = 1'b1;
    end
  endtask

  initial begin
    int acc, nresp;
    logic prev;
    rst_b = 1'b1;
    bus.req_valid = 1'b0;
    bus.mem_addr = '0;
    bus.mem_write_en = 1'b0;
    bus.mem_data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.misalign_err}, 32'd0);
    chk("rst_data", bus.mem_data_out, 32'd0);
    rst_b = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    op(32'h10, 1'b1, 32'h11223344, obs);
    op(32'h10, 1'b0, 32'h0, obs);
    chk("be_word", obs, 32'h11223344);
    chk("be_byte0", {24'd0, bus.mem_data_out[0]}, 32'h11);
    chk("be_byte3", {24'd0, bus.mem_data_out[3]}, 32'h44);
    op(32'h1000, 1'b1, 32'hDEADBEEF, obs);
    op(32'h0, 1'b0, 32'h0, obs);
    chk("wrap_read", obs, 32'hDEADBEEF);
    op(32'h20, 1'b1, 32'h12345678, obs);
    op(32'h22, 1'b1, 32'hAAAAAAAA, obs);
    op(32'h20, 1'b0, 32'h0, obs);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    chk("misalign_keep", obs, 32'h12345678);
`else
    chk("misalign_write", obs, 32'hAAAAAAAA);
`endif
    op(32'h8, 1'b1, 32'hCAFEF00D, obs);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_addr = 32'h8;
    bus.mem_write_en = 1'b1;
    bus.mem_data_in = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("midrst_resp", {31'd0, bus.resp_valid}, 32'd0);
      chk("midrst_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    rst_b = 1'b0;
    op(32'h8, 1'b0, 32'h0, obs);
    chk("midrst_keep", obs, 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_addr = 32'h10;
    bus.mem_write_en = 1'b0;
    acc = 0;
    nresp = 0;
    prev = 1'b0;
    for (int i = 0; i < 4 * (LAT + 1) + LAT + 2; i++) begin
      if (i == 4 * (LAT + 1)) bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) acc++;
      if (bus.resp_valid) begin
        nresp++;
        chk("cont_data", bus.mem_data_out, mm[4]);
      end
      chk("cont_b2b", {31'd0, prev & bus.resp_valid}, 32'd0);
      prev = bus.resp_valid;
      @(negedge clk);
    end
    chk("cont_accepts", 32'(acc), 32'd4);
    chk("cont_resps", 32'(nresp), 32'd4);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                       | ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 3)) : 32'd0);
      op(a, 1'($urandom), $urandom, obs);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
